// File: rtl/matrix_scan_bcm_pkg.sv
// matrix_scan_bcm_pkg: shared scan states and width helper for the BCM panel scanner
package matrix_scan_bcm_pkg;
  typedef enum logic [1:0] {ST_SHIFT, ST_WAIT, ST_BLANK, ST_LATCH} scan_state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/matrix_scan_bcm_if.sv
// matrix_scan_bcm_if: panel-side signals of the scanner; master is the scanner, slave the panel/fetch side
interface matrix_scan_bcm_if #(
  parameter int COLUMNS        = 64,
  parameter int ROW_ADDR_WIDTH = 4,
  parameter int BIT_DEPTH      = 6
);
  import matrix_scan_bcm_pkg::*;
  logic [7:0]                  global_brightness;
  logic [clog2(COLUMNS)-1:0]   column_address;
  logic [ROW_ADDR_WIDTH-1:0]   row_address;
  logic [ROW_ADDR_WIDTH-1:0]   row_address_active;
  logic [BIT_DEPTH-1:0]        brightness_mask;
  logic                        clk_pixel_load;
  logic                        clk_pixel;
  logic                        row_latch;
  logic                        output_enable;
  logic                        frame_start;
  modport master (
    input  global_brightness,
    output column_address, row_address, row_address_active, brightness_mask,
           clk_pixel_load, clk_pixel, row_latch, output_enable, frame_start
  );
  modport slave (
    output global_brightness,
    input  column_address, row_address, row_address_active, brightness_mask,
           clk_pixel_load, clk_pixel, row_latch, output_enable, frame_start
  );
endinterface

// File: rtl/matrix_scan_bcm_window_timer.sv
// bcm_window_timer: per-plane display window and brightness-scaled on-time counters, loaded at latch
module bcm_window_timer import matrix_scan_bcm_pkg::*; #(
  parameter int BIT_DEPTH  = 6,
  parameter int BASE_TICKS = 16
) (
  input  logic                        clk_in,
  input  logic                        reset,
  input  logic                        load,
  input  logic [clog2(BIT_DEPTH)-1:0] plane,
  input  logic [7:0]                  brightness,
  output logic                        window_done,
  output logic                        on
);
  localparam int CW = clog2((BASE_TICKS << (BIT_DEPTH - 1)) + 1);
  logic [CW-1:0] win_cnt, on_cnt, win_len;
  logic [CW+8:0] product;
  always_comb begin
    win_len = CW'(BASE_TICKS) << plane;
    product = (CW+9)'(win_len) * (CW+9)'({1'b0, brightness} + 9'd1);
  end
  always_ff @(posedge clk_in) begin
    if (reset) begin
      win_cnt <= '0;
      on_cnt  <= '0;
    end else if (load) begin
      win_cnt <= win_len;
      on_cnt  <= CW'(product >> 8);
    end else begin
      win_cnt <= (win_cnt != '0) ? win_cnt - CW'(1) : win_cnt;
      on_cnt  <= (on_cnt != '0) ? on_cnt - CW'(1) : on_cnt;
    end
  end
  // done also when this is the window's final cycle, so blanking follows with no gap
  assign window_done = win_cnt <= CW'(1);
  assign on          = on_cnt != '0;
endmodule

// File: rtl/matrix_scan_bcm.sv
// matrix_scan_bcm: HUB75-style row/plane scanner with binary-coded modulation, display overlapping next shift
module matrix_scan_bcm import matrix_scan_bcm_pkg::*; #(
  parameter int COLUMNS        = 64,
  parameter int ROW_ADDR_WIDTH = 4,
  parameter int BIT_DEPTH      = 6,
  parameter int BASE_TICKS     = 16
) (
  input logic                clk_in,
  input logic                reset,
  matrix_scan_bcm_if.master  bus
);
  localparam int CAW = clog2(COLUMNS);
  localparam int PW  = clog2(BIT_DEPTH);
  scan_state_t               state, state_nx;
  logic [CAW-1:0]            col, col_nx;
  logic                      phase_b, phase_b_nx;
  logic [ROW_ADDR_WIDTH-1:0] row, row_nx, row_active, row_active_nx;
  logic [PW-1:0]             plane, plane_nx;
  logic                      run, last_col, last_plane, window_done, on, latch;
  assign last_col   = col == CAW'(COLUMNS - 1);
  assign last_plane = plane == PW'(BIT_DEPTH - 1);
  assign latch      = run && state == ST_LATCH;
  // run holds outputs low during reset and releases the scan one edge later
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state      <= ST_SHIFT;
      col        <= '0;
      phase_b    <= 1'b0;
      row        <= '0;
      row_active <= '0;
      plane      <= '0;
      run        <= 1'b0;
    end else begin
      state      <= state_nx;
      col        <= col_nx;
      phase_b    <= phase_b_nx;
      row        <= row_nx;
      row_active <= row_active_nx;
      plane      <= plane_nx;
      run        <= 1'b1;
    end
  end
  always_comb begin
    state_nx      = state;
    col_nx        = col;
    phase_b_nx    = phase_b;
    row_nx        = row;
    row_active_nx = row_active;
    plane_nx      = plane;
    if (run) begin
      case (state)
        ST_SHIFT: begin
          phase_b_nx = !phase_b;
          col_nx     = phase_b ? (last_col ? '0 : col + CAW'(1)) : col;
          state_nx   = (phase_b && last_col) ? (window_done ? ST_BLANK : ST_WAIT) : ST_SHIFT;
        end
        ST_WAIT:  state_nx = window_done ? ST_BLANK : ST_WAIT;
        ST_BLANK: state_nx = ST_LATCH;
        default: begin
          state_nx      = ST_SHIFT;
          row_active_nx = row;
          plane_nx      = last_plane ? '0 : plane + PW'(1);
          row_nx        = last_plane ? row + ROW_ADDR_WIDTH'(1) : row;
        end
      endcase
    end
  end
  bcm_window_timer #(.BIT_DEPTH(BIT_DEPTH), .BASE_TICKS(BASE_TICKS)) u_timer (
    .clk_in      (clk_in),
    .reset       (reset),
    .load        (latch),
    .plane       (plane),
    .brightness  (bus.global_brightness),
    .window_done (window_done),
    .on          (on)
  );
  assign bus.column_address     = run ? col : '0;
  assign bus.row_address        = run ? row : '0;
  assign bus.row_address_active = run ? row_active : '0;
  assign bus.brightness_mask    = run ? BIT_DEPTH'(1) << plane : '0;
  assign bus.clk_pixel_load     = run && state == ST_SHIFT && !phase_b;
  assign bus.clk_pixel          = run && state == ST_SHIFT && phase_b;
  assign bus.row_latch          = latch;
  assign bus.output_enable      = run && on && state != ST_BLANK && state != ST_LATCH;
  assign bus.frame_start        = bus.clk_pixel_load && col == '0 && row == '0 && plane == '0;
endmodule

// File: tb/tb_matrix_scan_bcm.sv
// tb_matrix_scan_bcm: two scanners (BASE_TICKS 4 and 8) checked against a schedule-level reference model
module tb_matrix_scan_bcm;
  localparam int C = 4, RW = 1, BD = 2, N = 200;
  typedef int vec_t[9];
  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  always #5 clk_in = ~clk_in;
  matrix_scan_bcm_if #(.COLUMNS(C), .ROW_ADDR_WIDTH(RW), .BIT_DEPTH(BD)) bus_a();
  matrix_scan_bcm_if #(.COLUMNS(C), .ROW_ADDR_WIDTH(RW), .BIT_DEPTH(BD)) bus_b();
  matrix_scan_bcm #(.COLUMNS(C), .ROW_ADDR_WIDTH(RW), .BIT_DEPTH(BD), .BASE_TICKS(4)) dut_a (
    .clk_in(clk_in), .reset(reset), .bus(bus_a));
  matrix_scan_bcm #(.COLUMNS(C), .ROW_ADDR_WIDTH(RW), .BIT_DEPTH(BD), .BASE_TICKS(8)) dut_b (
    .clk_in(clk_in), .reset(reset), .bus(bus_b));
  int compared = 0, mismatched = 0;
  int bright[N];
  vec_t exp_v[2][N];
  vec_t obs_v[2][N];
  string names[9] = '{"column_address", "row_address", "row_address_active", "brightness_mask",
                      "clk_pixel_load", "clk_pixel", "row_latch", "output_enable", "frame_start"};
  function automatic vec_t grab(input int d);
    vec_t v;
    if (d == 0)
      v = '{int'(bus_a.column_address), int'(bus_a.row_address), int'(bus_a.row_address_active),
            int'(bus_a.brightness_mask), int'(bus_a.clk_pixel_load), int'(bus_a.clk_pixel),
            int'(bus_a.row_latch), int'(bus_a.output_enable), int'(bus_a.frame_start)};
    else
      v = '{int'(bus_b.column_address), int'(bus_b.row_address), int'(bus_b.row_address_active),
            int'(bus_b.brightness_mask), int'(bus_b.clk_pixel_load), int'(bus_b.clk_pixel),
            int'(bus_b.row_latch), int'(bus_b.output_enable), int'(bus_b.frame_start)};
    return v;
  endfunction
  // Reference schedule: each plane shifts for 2*C cycles, blanks once both shift and prior window are over,
  // latches the next cycle, then displays for W = base<<b with on-time scaled by the brightness seen at latch.
  task automatic build_model(input int d, input int base);
    int t, prev_end, r, b, act, blank, lat, w, on;
    for (int k = 0; k < N; k++) exp_v[d][k] = '{default: 0};
    t = 0; prev_end = -1; r = 0; b = 0; act = 0;
    while (t < N) begin
      for (int i = 0; i < 2 * C; i++)
        if (t + i < N) begin
          exp_v[d][t+i][0] = i / 2;
          exp_v[d][t+i][4] = (i % 2 == 0);
          exp_v[d][t+i][5] = i % 2;
          exp_v[d][t+i][8] = (i == 0 && r == 0 && b == 0);
        end
      blank = (t + 2 * C > prev_end + 1) ? t + 2 * C : prev_end + 1;
      lat   = blank + 1;
      for (int k = t; k <= lat && k < N; k++) begin
        exp_v[d][k][1] = r;
        exp_v[d][k][2] = act;
        exp_v[d][k][3] = 1 << b;
      end
      w = base << b;
      if (lat < N) begin
        exp_v[d][lat][6] = 1;
        on = (w * (bright[lat] + 1)) >> 8;
        for (int k = lat + 1; k <= lat + on && k < N; k++) exp_v[d][k][7] = 1;
      end
      prev_end = lat + w;
      act = r;
      b = (b + 1) % BD;
      if (b == 0) r = (r + 1) % (1 << RW);
      t = lat + 1;
    end
  endtask
  task automatic run_capture();
    reset = 1'b1;
    bus_a.global_brightness = 8'(bright[0]);
    bus_b.global_brightness = 8'(bright[0]);
    repeat (3) @(negedge clk_in);
    reset = 1'b0;
    for (int k = 0; k < N; k++) begin
      @(negedge clk_in);
      obs_v[0][k] = grab(0);
      obs_v[1][k] = grab(1);
      bus_a.global_brightness = 8'(bright[k]);
      bus_b.global_brightness = 8'(bright[k]);
    end
  endtask
  task automatic test_reset();
    vec_t v;
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      bus_a.global_brightness = 8'($urandom_range(0, 255));
      bus_b.global_brightness = bus_a.global_brightness;
      for (int d = 0; d < 2; d++) begin
        v = grab(d);
        for (int f = 0; f < 9; f++) begin
          compared++;
          if (v[f] !== 0) begin
            mismatched++;
            $display("FAIL reset dut%0d %s: got %0d expected 0", d, names[f], v[f]);
          end
        end
      end
    end
  endtask
  task automatic test_brightness_levels();
    int lv[3] = '{255, 127, 0};
    int on_tab[3][2] = '{'{4, 8}, '{2, 4}, '{0, 0}};
    int lat_cyc[5] = '{9, 19, 29, 39, 49};
    int e;
    for (int l = 0; l < 3; l++) begin
      for (int k = 0; k < N; k++) bright[k] = lv[l];
      build_model(0, 4);
      build_model(1, 8);
      run_capture();
      for (int d = 0; d < 2; d++)
        for (int k = 0; k < N; k++)
          for (int f = 0; f < 9; f++) begin
            compared++;
            if (obs_v[d][k][f] !== exp_v[d][k][f]) begin
              mismatched++;
              $display("FAIL level%0d dut%0d cycle %0d %s: got %0d expected %0d",
                       lv[l], d, k, names[f], obs_v[d][k][f], exp_v[d][k][f]);
            end
          end
      for (int k = 0; k < 30; k++) begin
        e = (k >= 10 && k < 14) ? int'(k - 10 < on_tab[l][0]) :
            (k >= 20 && k < 28) ? int'(k - 20 < on_tab[l][1]) : 0;
        compared++;
        if (obs_v[0][k][7] !== e) begin
          mismatched++;
          $display("FAIL oe_level%0d cycle %0d: got %0d expected %0d", lv[l], k, obs_v[0][k][7], e);
        end
      end
      for (int i = 0; i < 5; i++) begin
        compared++;
        if (obs_v[0][lat_cyc[i]][6] !== 1 || obs_v[0][lat_cyc[i]-1][6] !== 0) begin
          mismatched++;
          $display("FAIL latch_level%0d cycle %0d: got %0d expected 1", lv[l], lat_cyc[i], obs_v[0][lat_cyc[i]][6]);
        end
      end
    end
  endtask
  task automatic test_wait_base8();
    int chk[8][3] = '{'{9, 6, 1}, '{19, 6, 1}, '{27, 6, 0}, '{37, 6, 1},
                      '{20, 7, 1}, '{35, 7, 1}, '{36, 7, 0}, '{37, 7, 0}};
    for (int k = 0; k < N; k++) bright[k] = 255;
    run_capture();
    for (int i = 0; i < 8; i++) begin
      compared++;
      if (obs_v[1][chk[i][0]][chk[i][1]] !== chk[i][2]) begin
        mismatched++;
        $display("FAIL wait8 cycle %0d %s: got %0d expected %0d", chk[i][0], names[chk[i][1]],
                 obs_v[1][chk[i][0]][chk[i][1]], chk[i][2]);
      end
    end
    for (int k = 28; k < 37; k++) begin
      compared++;
      if (obs_v[1][k][4] !== 0 || obs_v[1][k][5] !== 0) begin
        mismatched++;
        $display("FAIL wait8_idle cycle %0d: got load=%0d pix=%0d expected 0 0", k, obs_v[1][k][4], obs_v[1][k][5]);
      end
    end
  endtask
  task automatic test_random_scan();
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < N; k++) bright[k] = $urandom_range(0, 255);
      build_model(0, 4);
      build_model(1, 8);
      run_capture();
      for (int d = 0; d < 2; d++)
        for (int k = 0; k < N; k++)
          for (int f = 0; f < 9; f++) begin
            compared++;
            if (obs_v[d][k][f] !== exp_v[d][k][f]) begin
              mismatched++;
              $display("FAIL random%0d dut%0d cycle %0d %s: got %0d expected %0d",
                       r, d, k, names[f], obs_v[d][k][f], exp_v[d][k][f]);
            end
          end
    end
  endtask
  task automatic test_row_wrap();
    int chk[10][3] = '{'{0, 8, 1}, '{10, 8, 0}, '{20, 8, 0}, '{39, 6, 1}, '{39, 1, 1},
                       '{40, 8, 1}, '{40, 1, 0}, '{40, 2, 1}, '{49, 2, 1}, '{50, 2, 0}};
    for (int k = 0; k < N; k++) bright[k] = $urandom_range(0, 255);
    run_capture();
    for (int i = 0; i < 10; i++) begin
      compared++;
      if (obs_v[0][chk[i][0]][chk[i][1]] !== chk[i][2]) begin
        mismatched++;
        $display("FAIL wrap cycle %0d %s: got %0d expected %0d", chk[i][0], names[chk[i][1]],
                 obs_v[0][chk[i][0]][chk[i][1]], chk[i][2]);
      end
    end
  endtask
  task automatic test_reset_mid_window();
    vec_t v;
    int i;
    reset = 1'b1;
    bus_a.global_brightness = 8'd255;
    bus_b.global_brightness = 8'd255;
    repeat (3) @(negedge clk_in);
    reset = 1'b0;
    for (i = 0; i < 100 && bus_a.output_enable !== 1'b1; i++) @(negedge clk_in);
    compared++;
    if (bus_a.output_enable !== 1'b1) begin
      mismatched++;
      $display("FAIL midreset_wait_oe: got %0d expected 1 within 100 cycles", bus_a.output_enable);
    end else begin
      reset = 1'b1;
      @(posedge clk_in);
      #1;
      for (int d = 0; d < 2; d++) begin
        v = grab(d);
        for (int f = 0; f < 9; f++) begin
          compared++;
          if (v[f] !== 0) begin
            mismatched++;
            $display("FAIL midreset dut%0d %s: got %0d expected 0", d, names[f], v[f]);
          end
        end
      end
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_brightness_levels();
    test_wait_base8();
    test_random_scan();
    test_row_wrap();
    test_reset_mid_window();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/matrix_scan_bcm.md
MATRIX_SCAN_BCM -- requirements
Module: matrix_scan_bcm

Interface
REQ-001 SHALL have parameter COLUMNS, default 64, meaning pixels shifted per row-plane.
REQ-002 SHALL have parameter ROW_ADDR_WIDTH, default 4, meaning row address bits; rows = 2^ROW_ADDR_WIDTH.
REQ-003 SHALL have parameter BIT_DEPTH, default 6, meaning bit planes per colour channel.
REQ-004 SHALL have parameter BASE_TICKS, default 16, meaning display window of plane 0, in clk_in cycles.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 clk_in  in  1  sole clock; all state changes on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 global_brightness  in  8  display duty scale; sampled at each latch.
REQ-009 column_address  out  clog2(COLUMNS)  column being shifted.
REQ-010 row_address  out  ROW_ADDR_WIDTH  row being shifted (fetch side).
REQ-011 row_address_active  out  ROW_ADDR_WIDTH  row currently latched/displayed (panel A-D).
REQ-012 brightness_mask  out  BIT_DEPTH  one-hot plane being shifted.
REQ-013 clk_pixel_load  out  1  fetch strobe, one cycle per column.
REQ-014 clk_pixel  out  1  panel shift clock.
REQ-015 row_latch  out  1  panel latch pulse.
REQ-016 output_enable  out  1  active-high display enable (inverted at pin).
REQ-017 frame_start  out  1  one-cycle pulse when shifting of row 0 plane 0 begins.

Function
REQ-018 Scan order SHALL be row outer, plane inner: (r,0)..(r,BIT_DEPTH-1), then r+1; last row wraps to row 0 and pulses frame_start.
REQ-019 States SHALL be SHIFT, WAIT, BLANK, LATCH; SHIFT always begins immediately after LATCH.
REQ-020 SHIFT SHALL take 2 cycles per column: cycle A column_address=c, clk_pixel_load=1, clk_pixel=0; cycle B clk_pixel=1, clk_pixel_load=0; c runs 0..COLUMNS-1.
REQ-021 After the last cycle B, SHALL go to WAIT; WAIT exits the cycle the previous plane's display window has expired, or immediately if expired or none.
REQ-022 BLANK SHALL last 1 cycle with output_enable=0; LATCH SHALL last 1 cycle with row_latch=1, output_enable=0.
REQ-023 At LATCH, row_address_active SHALL take the just-shifted row; the display window for that plane SHALL start the next cycle.
REQ-024 Window length for plane b SHALL be W_b = BASE_TICKS << b; OE on-time SHALL be (W_b*(global_brightness+1))>>8 cycles, computed at LATCH with full-width intermediates.
REQ-025 output_enable SHALL be 1 for exactly the on-time cycles starting the cycle after LATCH; it SHALL be 0 for the rest of the window.
REQ-026 Display of plane N SHALL overlap SHIFT of plane N+1.
REQ-027 On-time 0 SHALL give no output_enable pulse for that plane; on-time never exceeds W_b.
REQ-028 The display counter SHALL be wide enough for BASE_TICKS<<(BIT_DEPTH-1) without wrap.
REQ-029 A global_brightness change SHALL take effect only at the next LATCH.

Reset
REQ-030 While reset is high, all outputs SHALL be 0, counters SHALL clear, state SHALL be SHIFT at (row 0, plane 0), and no window is pending.
REQ-031 The first cycle after reset deasserts SHALL be cycle A of column 0 with frame_start=1.
REQ-032 Reset mid-window SHALL drop output_enable and row_latch to 0 on the next edge.

Structure
REQ-033 The state enum and clog2 helper SHALL live in the shared package; the window/on-time calculator SHALL be the sub-module bcm_window_timer.

Verification (COLUMNS=4, ROW_ADDR_WIDTH=1, BIT_DEPTH=2, BASE_TICKS=4; cycle 0 = first cycle after reset deasserts)
REQ-034 Reset release -> frame_start=1 at cycle 0; SHIFT cycles 0-7; BLANK at 8; row_latch=1 at cycle 9; output_enable=0 in cycles 0-9.
REQ-035 Brightness 255 -> plane 0 output_enable high for 4 cycles (10-13); plane 1 high for 8 cycles; no WAIT cycles.
REQ-036 Brightness 127 -> on-times of 2 and 4 cycles; windows stay 4 and 8.
REQ-037 Brightness 0 -> output_enable never asserts; latches still occur every 10 cycles when the window is ≤ 8.
REQ-038 BASE_TICKS=8 and brightness 255 -> plane 1 window is 16 cycles, giving 8 WAIT cycles before BLANK; output_enable=0 in BLANK and LATCH.
REQ-039 Row wrap and reset -> after (1,1) latches, row_address=0 and frame_start pulses; row_address_active becomes 0 only at the next latch; reset while output_enable=1 makes all outputs 0 on the next edge.
